// File: rtl/priority_request_arbiter.sv
// Priority request arbiter: sticky pending capture, enable masking, fixed
// priority selection (bit 3 highest) and a valid/ready offer of the encoded
// index. A mandatory IDLE bubble follows every accepted offer.
module priority_request_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [N_REQ-1:0] pending,
    output logic             overflow
);

    // The encoder below is written for exactly four lines.
    if (N_REQ != 4 || IDX_W != 2) begin : g_bad_cfg
        $error("priority_request_arbiter: only N_REQ=4, IDX_W=2 is supported");
    end

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_OFFER = 1'b1;

    logic             state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] elig;
    logic [IDX_W-1:0] sel_idx;

    // Handshake and the one-hot clear of the serviced bit.
    always_comb begin
        accept = (state_q == ST_OFFER) && grant_ready;
        clr    = '0;
        if (accept) begin
            clr[idx_q] = 1'b1;
        end
    end

    // Sticky pending update; a new request wins over a same-cycle clear.
    always_comb begin
        pending_d  = (pending_q & ~clr) | req_in;
        overflow_d = |(req_in & pending_q & ~clr);
    end

    // Highest set eligible bit; only consumed when elig is non-zero.
    always_comb begin
        elig = pending_q & mask;
        if (elig[3]) begin
            sel_idx = 2'd3;
        end else if (elig[2]) begin
            sel_idx = 2'd2;
        end else if (elig[1]) begin
            sel_idx = 2'd1;
        end else begin
            sel_idx = 2'd0;
        end
    end

    // Offer FSM; the index is frozen for the whole OFFER state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (elig != '0) begin
                    idx_d   = sel_idx;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign grant_valid = (state_q == ST_OFFER);
    assign grant_idx   = idx_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_priority_request_arbiter.sv
// Directed bench for priority_request_arbiter with hand-computed expectations.
module tb_priority_request_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       grant_ready;
    logic [3:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    priority_request_arbiter #(
        .N_REQ (4),
        .IDX_W (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .mask        (mask),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_in      = 4'b0000;
        mask        = 4'b1111;
        grant_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_idx", 32'(grant_idx), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);

        // 1: single request, two cycles to offer, cleared on accept
        req_in = 4'b0100;
        tick();
        req_in = 4'b0000;
        check("t1_pending", 32'(pending), 32'h4);
        check("t1_valid0", 32'(grant_valid), 32'h0);
        tick();
        check("t1_valid1", 32'(grant_valid), 32'h1);
        check("t1_idx", 32'(grant_idx), 32'h2);
        tick();
        check("t1_pend_clr", 32'(pending), 32'h0);
        check("t1_valid_clr", 32'(grant_valid), 32'h0);

        // 2: 1011 served as 3, 1, 0 with an IDLE bubble between grants
        req_in = 4'b1011;
        tick();
        req_in = 4'b0000;
        check("t2_pend_a", 32'(pending), 32'hb);
        tick();
        check("t2_valid_3", 32'(grant_valid), 32'h1);
        check("t2_idx_3", 32'(grant_idx), 32'h3);
        tick();
        check("t2_pend_b", 32'(pending), 32'h3);
        check("t2_bubble_b", 32'(grant_valid), 32'h0);
        tick();
        check("t2_idx_1", 32'(grant_idx), 32'h1);
        check("t2_valid_1", 32'(grant_valid), 32'h1);
        tick();
        check("t2_pend_c", 32'(pending), 32'h1);
        tick();
        check("t2_idx_0", 32'(grant_idx), 32'h0);
        check("t2_valid_0", 32'(grant_valid), 32'h1);
        tick();
        check("t2_pend_d", 32'(pending), 32'h0);
        check("t2_bubble_d", 32'(grant_valid), 32'h0);

        // 3: offered index held while a higher request arrives
        grant_ready = 1'b0;
        req_in      = 4'b0001;
        tick();
        req_in = 4'b0000;
        tick();
        check("t3_idx0", 32'(grant_idx), 32'h0);
        req_in = 4'b1000;
        tick();
        req_in = 4'b0000;
        check("t3_pend", 32'(pending), 32'h9);
        check("t3_hold_idx", 32'(grant_idx), 32'h0);
        check("t3_hold_valid", 32'(grant_valid), 32'h1);
        tick();
        check("t3_hold_idx2", 32'(grant_idx), 32'h0);
        grant_ready = 1'b1;
        tick();
        check("t3_pend_acc", 32'(pending), 32'h8);
        check("t3_bubble", 32'(grant_valid), 32'h0);
        tick();
        check("t3_idx3", 32'(grant_idx), 32'h3);
        check("t3_valid3", 32'(grant_valid), 32'h1);
        tick();
        check("t3_pend_end", 32'(pending), 32'h0);

        // 4: masked request stays pending and is not offered
        mask   = 4'b0111;
        req_in = 4'b1000;
        tick();
        req_in = 4'b0000;
        check("t4_pend", 32'(pending), 32'h8);
        tick();
        check("t4_masked_a", 32'(grant_valid), 32'h0);
        tick();
        check("t4_masked_b", 32'(grant_valid), 32'h0);
        mask = 4'b1111;
        tick();
        check("t4_valid", 32'(grant_valid), 32'h1);
        check("t4_idx", 32'(grant_idx), 32'h3);
        tick();
        check("t4_pend_end", 32'(pending), 32'h0);

        // 5a: repeat request on a pending bit raises a one-cycle overflow
        grant_ready = 1'b0;
        req_in      = 4'b0010;
        tick();
        check("t5_ovf_none", 32'(overflow), 32'h0);
        tick();
        req_in = 4'b0000;
        check("t5_ovf_hit", 32'(overflow), 32'h1);
        check("t5_idx1", 32'(grant_idx), 32'h1);
        tick();
        check("t5_ovf_drop", 32'(overflow), 32'h0);

        // 5b: re-request in the accept cycle: no overflow, bit stays pending
        grant_ready = 1'b1;
        req_in      = 4'b0010;
        tick();
        req_in = 4'b0000;
        check("t5_setwins_pend", 32'(pending), 32'h2);
        check("t5_setwins_ovf", 32'(overflow), 32'h0);
        check("t5_setwins_bub", 32'(grant_valid), 32'h0);
        tick();
        check("t5_reoffer_v", 32'(grant_valid), 32'h1);
        check("t5_reoffer_i", 32'(grant_idx), 32'h1);
        tick();
        check("t5_pend_end", 32'(pending), 32'h0);

        // 6: reset mid-offer with everything pending
        grant_ready = 1'b0;
        req_in      = 4'b1111;
        tick();
        req_in = 4'b0000;
        tick();
        check("t6_pre_valid", 32'(grant_valid), 32'h1);
        check("t6_pre_pend", 32'(pending), 32'hf);
        rst_n  = 1'b0;
        req_in = 4'b1111;
        tick();
        rst_n  = 1'b1;
        req_in = 4'b0000;
        check("t6_valid", 32'(grant_valid), 32'h0);
        check("t6_pend", 32'(pending), 32'h0);
        check("t6_idx", 32'(grant_idx), 32'h0);
        check("t6_ovf", 32'(overflow), 32'h0);
        tick();
        check("t6_post_pend", 32'(pending), 32'h0);
        check("t6_post_valid", 32'(grant_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
